// File: rtl/spike_rate_encoder_if.sv
// Sample-input handshake between a producer and spike_rate_encoder.
// The producer offers in_data with in_valid; the encoder answers with combinational in_ready.
interface spike_rate_encoder_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/spike_rate_encoder.sv
// Sigma-delta rate encoder: each accepted sample produces a WINDOW-cycle spike train whose
// spike count is floor(value*WINDOW / 2**DATA_W). Back-to-back windows chain without a bubble.
module spike_rate_encoder #(
   parameter int DATA_W = 8,
   parameter int WINDOW = 16,
   localparam int CNT_W = $clog2(WINDOW + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   spike_rate_encoder_if.slave  bus,
   output logic                 spike_out,
   output logic                 window_done,
   output logic [CNT_W-1:0]     spike_count,
   output logic                 busy
);
   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_RUN   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   logic [0:0]        r_state;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_value;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_nspk;
   logic              r_spike;
   logic              r_done;
   logic [CNT_W-1:0]  r_spike_count;

   logic              w_last;
   logic              w_accept;
   logic [DATA_W:0]   w_sum;
   logic              w_carry;
   logic [CNT_W-1:0]  w_nspk_next;

   assign w_last       = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
   assign bus.in_ready = (r_state == ST_IDLE) || w_last;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_sum        = {1'b0, r_acc} + {1'b0, r_value};
   assign w_carry      = w_sum[DATA_W];
   assign w_nspk_next  = r_nspk + CNT_W'(w_carry);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_acc         <= '0;
         r_value       <= '0;
         r_cnt         <= '0;
         r_nspk        <= '0;
         r_spike       <= 1'b0;
         r_done        <= 1'b0;
         r_spike_count <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_RUN) begin
            r_acc   <= w_sum[DATA_W-1:0];
            r_spike <= w_carry;
            r_nspk  <= w_nspk_next;
            if (w_last) begin
               r_done        <= 1'b1;
               r_spike_count <= w_nspk_next;
               r_state       <= ST_IDLE;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_spike <= 1'b0;
         end
         // A reload overrides the bookkeeping above; the last spike of the old window still goes out.
         if (w_accept) begin
            r_value <= bus.in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_nspk  <= '0;
            r_state <= ST_RUN;
         end
      end
   end

   assign spike_out   = r_spike;
   assign window_done = r_done;
   assign spike_count = r_spike_count;
   assign busy        = (r_state == ST_RUN);
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: a WINDOW=16 instance for most scenarios and a
// WINDOW=256 instance for the near-full-scale case.
module tb_spike_rate_encoder;
   logic clk;
   logic reset;

   logic       a_spike, a_done, a_busy;
   logic [4:0] a_count;
   logic       b_spike, b_done, b_busy;
   logic [8:0] b_count;

   int n_cmp;
   int n_err;

   spike_rate_encoder_if #(.DATA_W(8)) a_if ();
   spike_rate_encoder_if #(.DATA_W(8)) b_if ();

   spike_rate_encoder #(.DATA_W(8), .WINDOW(16)) u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .bus         (a_if.slave),
      .spike_out   (a_spike),
      .window_done (a_done),
      .spike_count (a_count),
      .busy        (a_busy)
   );

   spike_rate_encoder #(.DATA_W(8), .WINDOW(256)) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .bus         (b_if.slave),
      .spike_out   (b_spike),
      .window_done (b_done),
      .spike_count (b_count),
      .busy        (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Position k (1-based) spikes when floor(k*v/256) steps up.
   function automatic logic exp_spike(input int v, input int k);
      return ((k * v) / 256) != (((k - 1) * v) / 256);
   endfunction

   // Called right after the accept edge; checks the 16 window positions on instance A.
   task automatic check_window_a(input int v, input int exp_cnt, input bit chained);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("a_spike v=%0d k=%0d", v, k), 32'(a_spike), 32'(exp_spike(v, k)));
         chk($sformatf("a_done v=%0d k=%0d", v, k), 32'(a_done), 32'(k == 16));
         if (k < 16) begin
            chk($sformatf("a_ready v=%0d k=%0d", v, k), 32'(a_if.in_ready), 32'(k == 15));
            chk($sformatf("a_busy v=%0d k=%0d", v, k), 32'(a_busy), 32'd1);
         end else begin
            chk($sformatf("a_count v=%0d", v), 32'(a_count), 32'(exp_cnt));
            chk($sformatf("a_busy_end v=%0d", v), 32'(a_busy), 32'(chained));
            chk($sformatf("a_ready_end v=%0d", v), 32'(a_if.in_ready), 32'(!chained));
         end
      end
   endtask

   task automatic accept_a(input int v);
      a_if.in_valid = 1'b1;
      a_if.in_data  = 8'(v);
      step();
      a_if.in_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      a_if.in_valid = 1'b0;
      a_if.in_data  = '0;
      b_if.in_valid = 1'b0;
      b_if.in_data  = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk("rst_spike", 32'(a_spike), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_ready", 32'(a_if.in_ready), 32'd1);
      step();

      // Half scale: spikes on even positions, 8 total
      accept_a(128);
      check_window_a(128, 8, 1'b0);

      // Zero: silent window, done pulse still occurs
      accept_a(0);
      check_window_a(0, 0, 1'b0);
      step();
      chk("zero_done_once", 32'(a_done), 32'd0);

      // Held valid: 64 then 192 abut with no idle cycle
      a_if.in_valid = 1'b1;
      a_if.in_data  = 8'd64;
      step();
      a_if.in_data  = 8'd192;
      check_window_a(64, 4, 1'b1);
      a_if.in_valid = 1'b0;
      check_window_a(192, 12, 1'b0);

      // Valid dropped: idle, silent, count held
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_spike", 32'(a_spike), 32'd0);
         chk("idle_busy", 32'(a_busy), 32'd0);
         chk("idle_done", 32'(a_done), 32'd0);
         chk("idle_count_hold", 32'(a_count), 32'd12);
      end

      // Reset at cnt=7 abandons the window
      accept_a(128);
      for (int k = 1; k <= 7; k++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_spike", 32'(a_spike), 32'd0);
      chk("midrst_busy", 32'(a_busy), 32'd0);
      chk("midrst_ready", 32'(a_if.in_ready), 32'd1);
      chk("midrst_done", 32'(a_done), 32'd0);
      chk("midrst_count", 32'(a_count), 32'd0);
      for (int k = 0; k < 12; k++) begin
         step();
         chk("midrst_no_done", 32'(a_done), 32'd0);
      end

      // Near full scale on the 256-cycle window: only position 1 is silent
      b_if.in_valid = 1'b1;
      b_if.in_data  = 8'd255;
      step();
      b_if.in_valid = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         step();
         chk($sformatf("b_spike k=%0d", k), 32'(b_spike), 32'(k != 1));
         chk($sformatf("b_done k=%0d", k), 32'(b_done), 32'(k == 256));
      end
      chk("b_count", 32'(b_count), 32'd255);
      chk("b_busy_end", 32'(b_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
